mic_rec_play_ctrl: RTL and testbench
====================================

// Module: mic_rec_play_ctrl
// PURPOSE
//  Sequencer between the microphone deserializer and a single-port sample RAM (2**adr_width words).
//  Records mic samples on request, then plays them back at a fixed sample rate to the PCM output stage.
//  Owns the RAM address/write strobe and arbitrates record vs playback; exactly one operation runs at a time.
// PARAMETERS
//  adr_width   12    RAM address width; capacity = 2**adr_width samples
//  dat_width   6     sample width (mic, RAM and PCM output)
//  SAMPLE_DIV  2272  clk cycles per playback sample (>=3)
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  reset      in   1          synchronous, active-high
//  rec        in   1          1-cycle pulse: start recording (debounced upstream)
//  play       in   1          1-cycle pulse: start playback
//  stop       in   1          1-cycle pulse: abort current operation
//  mic_valid  in   1          1-cycle strobe, mic_data valid
//  mic_data   in   dat_width  sample from microphone deserializer
//  mem_we     out  1          RAM write enable
//  mem_addr   out  adr_width  RAM address
//  mem_wdata  out  dat_width  RAM write data
//  mem_rdata  in   dat_width  RAM read data, valid 1 cycle after address presented
//  pcm_valid  out  1          1-cycle strobe, new pcm_out sample
//  pcm_out    out  dat_width  playback sample, held between strobes
//  ledrec     out  1          high while state REC
//  ledplay    out  1          high while PLAY_WAIT/PLAY_RD
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, all outputs 0, rec_len=0, tick counter=0.
//  - rec_len: adr_width+1 bits, number of valid samples stored (0..2**adr_width).
//  - States: IDLE, REC, PLAY_WAIT, PLAY_RD.
//  - IDLE: rec -> REC (addr=0). play with rec_len!=0 -> PLAY_WAIT (addr=0, tick cnt=0).
//    play with rec_len==0 ignored. rec and play same cycle: rec wins. stop ignored.
//  - REC: each mic_valid -> next cycle mem_we=1, mem_wdata=mic_data, mem_addr=wr_ptr; wr_ptr++.
//    After write to addr 2**adr_width-1: rec_len=2**adr_width, -> IDLE (no wrap).
//    stop -> IDLE, rec_len=samples written; stop with concurrent mic_valid: sample dropped.
//  - PLAY_WAIT: count SAMPLE_DIV-1 cycles, then present rd_ptr on mem_addr -> PLAY_RD.
//  - PLAY_RD (1 cycle): latch mem_rdata into pcm_out, pcm_valid=1 for that cycle;
//    rd_ptr++; if rd_ptr was rec_len-1 -> IDLE, else -> PLAY_WAIT.
//    Sample period exactly SAMPLE_DIV clk cycles; first pcm_valid SAMPLE_DIV+1 cycles after play.
//  - stop in PLAY_*: -> IDLE next cycle, no further pcm_valid; pcm_out keeps last value.
//  - rec/play while not IDLE: ignored. mic_valid outside REC: ignored, mem_we stays 0.
//  - mem_we never asserted outside REC write cycles; rec_len unchanged by playback.
// CONFIGURATION
//  PLAY_LOOP_EN defined: after last sample (rd_ptr==rec_len-1) rd_ptr wraps to 0, stays in
//    PLAY_WAIT; playback repeats until stop or reset. Period unchanged across wrap.
//  PLAY_LOOP_EN undefined: single pass, returns to IDLE as above.
// STRUCTURE
//  Shared package: state encoding (IDLE/REC/PLAY_WAIT/PLAY_RD), default SAMPLE_DIV constant.
//  Sub-module: sample_tick_gen (SAMPLE_DIV counter, clear input, 1-cycle tick output).
// TESTING
//  1 reset mid-REC after 10 samples -> all outputs 0, rec_len=0, later play ignored.
//  2 rec, 5 mic_valid (data 1..5), stop -> mem_we 5 pulses, addr 0..4, data 1..5; rec_len=5.
//  3 play after (2), SAMPLE_DIV=4 -> pcm_valid every 4 cycles, pcm_out 1..5, then IDLE, ledplay=0.
//  4 adr_width=3, rec + 10 mic_valid -> 8 writes addr 0..7, IDLE after 8th, rec_len=8, writes 9-10 dropped.
//  5 rec and play same cycle in IDLE -> REC; play pulse during REC ignored; stop during play -> no more pcm_valid.
//  6 PLAY_LOOP_EN, rec_len=3 -> pcm_out 1,2,3,1,2,3... until stop; undefined -> single pass only.

Source files
------------

// File: rtl/mic_rec_play_ctrl_pkg.sv
// mic_rec_play_ctrl_pkg
//   Shared definitions for the microphone record/playback sequencer:
//   the controller state encoding and the default playback sample divider.
//   No ports (package).
package mic_rec_play_ctrl_pkg;

  // Controller states; exactly one operation (record or playback) at a time.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REC       = 2'd1,
    ST_PLAY_WAIT = 2'd2,
    ST_PLAY_RD   = 2'd3
  } state_t;

  // Default clk cycles per playback sample.
  localparam int unsigned SAMPLE_DIV_DEFAULT = 32'd2272;

endpackage

// File: rtl/mic_rec_play_ctrl_sample_tick_gen.sv
// sample_tick_gen
//   Free-running modulo-DIV cycle counter used to pace playback. The tick
//   fires once per DIV cycles, on the cycle where the count equals DIV-2, so
//   that a sequencer cleared together with this counter spends DIV-1 cycles
//   waiting and one cycle reading per sample.
// Ports
//   clk      in  1  system clock, rising edge
//   reset    in  1  synchronous, active-high
//   clear_i  in  1  restart the count at 0 on the next edge
//   tick_o   out 1  one-cycle pulse every DIV cycles
module sample_tick_gen
  import mic_rec_play_ctrl_pkg::*;
#(
  parameter int unsigned DIV = SAMPLE_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned   CW      = $clog2(DIV);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] TICK_AT = CW'(DIV - 2);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] cnt_q;

  // Modulo-DIV counter with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + ONE;
    end
  end

  // Decoded from the counter register only, so it is glitch-free per cycle.
  assign tick_o = (cnt_q == TICK_AT);

endmodule

// File: rtl/mic_rec_play_ctrl.sv
// mic_rec_play_ctrl
//   Sequencer between the microphone deserializer and a single-port sample
//   RAM of 2**adr_width words. Records mic samples on request and plays them
//   back at one sample per SAMPLE_DIV clk cycles. All outputs are registered.
//   Optional build macro: PLAY_LOOP_EN -- playback wraps to the first sample
//   and repeats until stop/reset; without it playback is a single pass.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   rec, play, stop       one-cycle command pulses
//   mic_valid, mic_data   incoming microphone samples
//   mem_we, mem_addr,     RAM write strobe, address, write data
//   mem_wdata, mem_rdata  and read data (valid 1 cycle after address)
//   pcm_valid, pcm_out    playback strobe and held playback sample
//   ledrec, ledplay       status: recording / playing
module mic_rec_play_ctrl
  import mic_rec_play_ctrl_pkg::*;
#(
  parameter int unsigned adr_width  = 12,
  parameter int unsigned dat_width  = 6,
  parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rec,
  input  logic                 play,
  input  logic                 stop,
  input  logic                 mic_valid,
  input  logic [dat_width-1:0] mic_data,
  output logic                 mem_we,
  output logic [adr_width-1:0] mem_addr,
  output logic [dat_width-1:0] mem_wdata,
  input  logic [dat_width-1:0] mem_rdata,
  output logic                 pcm_valid,
  output logic [dat_width-1:0] pcm_out,
  output logic                 ledrec,
  output logic                 ledplay
);

  // One extra bit so a completely full RAM (2**adr_width samples) is representable.
  localparam int unsigned   LW    = adr_width + 1;
  localparam logic [LW-1:0] ONE_L = LW'(1);

  state_t               state_q;
  logic [LW-1:0]        wr_cnt_q;
  logic [LW-1:0]        rd_ptr_q;
  logic [LW-1:0]        rec_len_q;
  logic                 mem_we_q;
  logic [adr_width-1:0] mem_addr_q;
  logic [dat_width-1:0] mem_wdata_q;
  logic                 pcm_valid_q;
  logic [dat_width-1:0] pcm_out_q;
  logic                 ledrec_q;
  logic                 ledplay_q;

  logic                 tick;
  logic                 play_start;
  logic [LW-1:0]        wr_cnt_inc;
  logic [LW-1:0]        rd_ptr_inc;
  logic [LW-1:0]        rec_last;

  assign wr_cnt_inc = wr_cnt_q + ONE_L;
  assign rd_ptr_inc = rd_ptr_q + ONE_L;
  assign rec_last   = rec_len_q - ONE_L;

  // Accepted playback start; also restarts the sample pacing counter so the
  // first sample lands a fixed number of cycles after the play pulse.
  assign play_start = (state_q == ST_IDLE) && !rec && play && (rec_len_q != '0);

  sample_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .clear_i (play_start),
    .tick_o  (tick)
  );

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      rec_len_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pcm_valid_q <= 1'b0;
      pcm_out_q   <= '0;
      ledrec_q    <= 1'b0;
      ledplay_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      mem_we_q    <= 1'b0;
      pcm_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rec) begin
            state_q    <= ST_REC;
            wr_cnt_q   <= '0;
            mem_addr_q <= '0;
            ledrec_q   <= 1'b1;
          end else if (play_start) begin
            state_q    <= ST_PLAY_WAIT;
            rd_ptr_q   <= '0;
            mem_addr_q <= '0;
            ledplay_q  <= 1'b1;
          end
        end
        ST_REC: begin
          if (stop) begin
            // A sample arriving together with stop is dropped.
            state_q   <= ST_IDLE;
            rec_len_q <= wr_cnt_q;
            ledrec_q  <= 1'b0;
          end else if (mic_valid) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= mic_data;
            mem_addr_q  <= wr_cnt_q[adr_width-1:0];
            wr_cnt_q    <= wr_cnt_inc;
            // Last RAM word written: recording ends, no wrap-around.
            if (wr_cnt_q[adr_width-1:0] == '1) begin
              state_q   <= ST_IDLE;
              rec_len_q <= wr_cnt_inc;
              ledrec_q  <= 1'b0;
            end
          end
        end
        ST_PLAY_WAIT: begin
          // mem_addr already holds rd_ptr, so read data is settled by PLAY_RD.
          if (stop) begin
            state_q   <= ST_IDLE;
            ledplay_q <= 1'b0;
          end else if (tick) begin
            state_q <= ST_PLAY_RD;
          end
        end
        ST_PLAY_RD: begin
          if (stop) begin
            state_q   <= ST_IDLE;
            ledplay_q <= 1'b0;
          end else begin
            pcm_out_q   <= mem_rdata;
            pcm_valid_q <= 1'b1;
            if (rd_ptr_q == rec_last) begin
`ifdef PLAY_LOOP_EN
              rd_ptr_q   <= '0;
              mem_addr_q <= '0;
              state_q    <= ST_PLAY_WAIT;
`else
              state_q    <= ST_IDLE;
              ledplay_q  <= 1'b0;
`endif
            end else begin
              rd_ptr_q   <= rd_ptr_inc;
              mem_addr_q <= rd_ptr_inc[adr_width-1:0];
              state_q    <= ST_PLAY_WAIT;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          ledrec_q  <= 1'b0;
          ledplay_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pcm_valid = pcm_valid_q;
  assign pcm_out   = pcm_out_q;
  assign ledrec    = ledrec_q;
  assign ledplay   = ledplay_q;

endmodule

// File: tb/tb_mic_rec_play_ctrl.sv
// tb_mic_rec_play_ctrl
//   Self-checking bench for mic_rec_play_ctrl (adr_width=3, SAMPLE_DIV=4).
//   A transaction-level model (sample array, recorded length, expected event
//   times) predicts RAM writes and playback strobes; monitors log what the
//   design actually does and the directed sequence compares the logs.
module tb_mic_rec_play_ctrl;

  localparam int AW  = 3;
  localparam int DW  = 6;
  localparam int DIV = 4;
  localparam int CAP = 8;
`ifdef PLAY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          rec       = 1'b0;
  logic          play      = 1'b0;
  logic          stop      = 1'b0;
  logic          mic_valid = 1'b0;
  logic [DW-1:0] mic_data  = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          pcm_valid;
  logic [DW-1:0] pcm_out;
  logic          ledrec;
  logic          ledplay;

  always #5 clk = ~clk;

  mic_rec_play_ctrl #(
    .adr_width  (AW),
    .dat_width  (DW),
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rec       (rec),
    .play      (play),
    .stop      (stop),
    .mic_valid (mic_valid),
    .mic_data  (mic_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pcm_valid (pcm_valid),
    .pcm_out   (pcm_out),
    .ledrec    (ledrec),
    .ledplay   (ledplay)
  );

  // Single-port synchronous RAM.
  logic [DW-1:0] ram [CAP];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs captured mid-cycle.
  int wr_addr_q[$];
  int wr_data_q[$];
  int pcm_data_q[$];
  int pcm_cyc_q[$];
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(int'(mem_wdata));
    end
    if (pcm_valid) begin
      pcm_data_q.push_back(int'(pcm_out));
      pcm_cyc_q.push_back(cyc);
    end
  end

  // Reference model state.
  int m_mem[CAP];
  int m_len      = 0;
  int m_last_pcm = 0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pcm_valid", pcm_valid, 0);
    chk("rst_pcm_out", pcm_out, 0);
    chk("rst_ledrec", ledrec, 0);
    chk("rst_ledplay", ledplay, 0);
  endtask

  task automatic start_rec();
    @(negedge clk); rec = 1'b1;
    @(negedge clk); rec = 1'b0;
    chk("ledrec_on", ledrec, 1);
  endtask

  // mode 0: stop after samples, 1: stop with a concurrent (dropped) sample, 2: no stop
  task automatic record(input int n, input int base, input int mode);
    int acc;
    int d;
    int exp_d[$];
    acc = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = (base >= 0) ? base + i : int'($urandom_range(0, 63));
      mic_valid = 1'b1;
      mic_data  = DW'(d);
      @(negedge clk);
      mic_valid = 1'b0;
      if (acc < CAP) begin
        m_mem[acc] = d;
        exp_d.push_back(d);
        acc++;
      end
    end
    if (mode != 2) begin
      stop = 1'b1;
      if (mode == 1) begin
        mic_valid = 1'b1;
        mic_data  = DW'($urandom_range(0, 63));
      end
      @(negedge clk);
      stop      = 1'b0;
      mic_valid = 1'b0;
      m_len     = acc;
    end
    repeat (2) @(negedge clk);
    chk("wr_count", wr_addr_q.size(), acc);
    for (int i = 0; i < acc && i < wr_addr_q.size(); i++) begin
      chk("wr_addr", wr_addr_q[i], i);
      chk("wr_data", wr_data_q[i], exp_d[i]);
    end
    if (mode != 2) chk("ledrec_off", ledrec, 0);
    else           chk("ledrec_held", ledrec, 1);
  endtask

  // rel > 0: stop pulse rel cycles after the play pulse; otherwise no stop.
  task automatic play_check(input int rel);
    int p;
    int s;
    int endc;
    int n_exp;
    pcm_data_q.delete();
    pcm_cyc_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    play = 1'b1;
    p    = cyc;
    s    = (rel > 0) ? p + rel : -1;
    if (LOOP && m_len > 0 && s < 0) s = p + 1 + DIV * (2 * m_len + 1);
    endc = (s >= 0) ? s + 3 * DIV : p + DIV + 1 + m_len * DIV + 3 * DIV;
    while (cyc < endc) begin
      @(negedge clk);
      play      = 1'b0;
      stop      = (cyc == s);
      rec       = (m_len > 0) && (cyc == p + 2) && (s < 0 || s > p + 3);
      mic_valid = rec;
      if (cyc == p + 1) chk("ledplay_on", ledplay, (m_len > 0) ? 1 : 0);
    end
    stop      = 1'b0;
    rec       = 1'b0;
    mic_valid = 1'b0;
    n_exp = 0;
    if (m_len > 0) begin
      for (int k = 0; k < 1000; k++) begin
        if (!LOOP && k >= m_len) break;
        if (s >= 0 && (p + DIV + 1 + k * DIV) > s) break;
        n_exp++;
      end
    end
    chk("pcm_count", pcm_data_q.size(), n_exp);
    for (int k = 0; k < n_exp && k < pcm_data_q.size(); k++) begin
      chk("pcm_data", pcm_data_q[k], m_mem[k % m_len]);
      chk("pcm_cyc", pcm_cyc_q[k], p + DIV + 1 + k * DIV);
    end
    if (n_exp > 0) m_last_pcm = m_mem[(n_exp - 1) % m_len];
    chk("pcm_hold", pcm_out, m_last_pcm);
    chk("ledplay_off", ledplay, 0);
    chk("ledrec_in_play", ledrec, 0);
    chk("no_wr_in_play", wr_addr_q.size(), 0);
  endtask

  initial begin
    // Power-on reset.
    repeat (3) @(negedge clk);
    check_all_zero();
    reset = 1'b0;

    // Reset in the middle of a recording clears everything; play is then ignored.
    start_rec();
    record(5, -1, 2);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero();
    reset      = 1'b0;
    m_len      = 0;
    m_last_pcm = 0;
    play_check(-1);

    // mic_valid and stop in IDLE produce no writes.
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk); stop = 1'b1; mic_valid = 1'b1; mic_data = 6'd9;
    @(negedge clk); stop = 1'b0;
    @(negedge clk); mic_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_wr", wr_addr_q.size(), 0);
    chk("idle_ledrec", ledrec, 0);

    // Record 1..5, then play it back.
    start_rec();
    record(5, 1, 0);
    play_check(-1);

    // Three samples: single pass, or repeating when looping is built in.
    start_rec();
    record(3, 1, 0);
    play_check(-1);

    // Overfill: only CAP samples stored, recording ends on its own.
    start_rec();
    record(10, -1, 0);
    play_check(-1);

    // rec and play together start recording; play during REC is ignored.
    @(negedge clk); rec = 1'b1; play = 1'b1;
    @(negedge clk); rec = 1'b0; play = 1'b0;
    chk("recplay_ledrec", ledrec, 1);
    chk("recplay_ledplay", ledplay, 0);
    @(negedge clk); play = 1'b1;
    @(negedge clk); play = 1'b0;
    chk("play_in_rec", ledplay, 0);
    record(4, -1, 1);
    play_check(int'($urandom_range(1, DIV * 5)));

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      start_rec();
      record(int'($urandom_range(0, 10)), -1, int'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) != 0) play_check(int'($urandom_range(1, DIV * (m_len + 1) + 2)));
      else                           play_check(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
